// File: rtl/jtag_pkg.sv
// Shared TAP definitions: 16-state encoding, decoded-state bundle,
// IR capture pattern and the BYPASS opcode test.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_TLR    = 4'h0,
    TAP_RTI    = 4'h1,
    TAP_SEL_DR = 4'h2,
    TAP_CAP_DR = 4'h3,
    TAP_SH_DR  = 4'h4,
    TAP_EX1_DR = 4'h5,
    TAP_PAU_DR = 4'h6,
    TAP_EX2_DR = 4'h7,
    TAP_UPD_DR = 4'h8,
    TAP_SEL_IR = 4'h9,
    TAP_CAP_IR = 4'hA,
    TAP_SH_IR  = 4'hB,
    TAP_EX1_IR = 4'hC,
    TAP_PAU_IR = 4'hD,
    TAP_EX2_IR = 4'hE,
    TAP_UPD_IR = 4'hF
  } tap_state_e;

  typedef struct packed {
    logic tlr;
    logic cap_dr;
    logic sh_dr;
    logic upd_dr;
    logic cap_ir;
    logic sh_ir;
    logic upd_ir;
  } tap_decode_t;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

  // True when the low 'width' bits of op are all ones (the BYPASS opcode).
  function automatic logic is_bypass_op(input logic [31:0] op, input int width);
    logic all_ones;
    all_ones = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i < width && !op[i]) all_ones = 1'b0;
    end
    return all_ones;
  endfunction

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// Pin-level and user data register signals of jtag_tap_ctrl.
// master drives TMS/TDI/user_tdo; slave is the controller.
interface jtag_tap_ctrl_if #(
  parameter int IR_WIDTH = 4
);
  logic                TMS;
  logic                TDI;
  logic                TDO;
  logic                TDO_EN;
  logic [IR_WIDTH-1:0] ir_out;
  logic                user_sel;
  logic                user_tdi;
  logic                user_tdo;
  logic                capture_dr;
  logic                shift_dr;
  logic                update_dr;
  logic                tlr;

  modport master (
    output TMS, TDI, user_tdo,
    input  TDO, TDO_EN, ir_out, user_sel, user_tdi,
           capture_dr, shift_dr, update_dr, tlr
  );

  modport slave (
    input  TMS, TDI, user_tdo,
    output TDO, TDO_EN, ir_out, user_sel, user_tdi,
           capture_dr, shift_dr, update_dr, tlr
  );
endinterface

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine with synchronous RST override and a
// decoded view of the states the data path acts on.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic        TCK,
  input  logic        RST,
  input  logic        TMS,
  output tap_decode_t dec
);

  tap_state_e state;
  tap_state_e state_next;

  always_ff @(posedge TCK) begin
    if (RST) state <= TAP_TLR;
    else     state <= state_next;
  end

  always_comb begin
    state_next = TAP_TLR;
    case (state)
      TAP_TLR:    state_next = TMS ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    state_next = TMS ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: state_next = TMS ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: state_next = TMS ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  state_next = TMS ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: state_next = TMS ? TAP_UPD_DR : TAP_PAU_DR;
      TAP_PAU_DR: state_next = TMS ? TAP_EX2_DR : TAP_PAU_DR;
      TAP_EX2_DR: state_next = TMS ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: state_next = TMS ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: state_next = TMS ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: state_next = TMS ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  state_next = TMS ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: state_next = TMS ? TAP_UPD_IR : TAP_PAU_IR;
      TAP_PAU_IR: state_next = TMS ? TAP_EX2_IR : TAP_PAU_IR;
      TAP_EX2_IR: state_next = TMS ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: state_next = TMS ? TAP_SEL_DR : TAP_RTI;
      default:    state_next = TAP_TLR;
    endcase
  end

  always_comb begin
    dec        = '0;
    dec.tlr    = (state == TAP_TLR);
    dec.cap_dr = (state == TAP_CAP_DR);
    dec.sh_dr  = (state == TAP_SH_DR);
    dec.upd_dr = (state == TAP_UPD_DR);
    dec.cap_ir = (state == TAP_CAP_IR);
    dec.sh_ir  = (state == TAP_SH_IR);
    dec.upd_ir = (state == TAP_UPD_IR);
  end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: IR, BYPASS, optional IDCODE, TDO mux and user DR strobes.
// Define JTAG_IDCODE_EN to build the IDCODE register and make it the reset instruction.
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH     = 4,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP    = IR_WIDTH'(4'b0001),
  parameter logic [31:0]         IDCODE_VALUE = 32'h1000_0001
) (
  input  logic           TCK,
  input  logic           RST,
  jtag_tap_ctrl_if.slave bus
);

`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RESET_OP = IDCODE_OP;
`else
  localparam logic [IR_WIDTH-1:0] RESET_OP = '1;
`endif

  // Marker block that only elaborates for an illegal parameter set.
  if (IR_WIDTH < 2 || !IDCODE_VALUE[0] || IDCODE_OP == '1) begin : g_illegal_params
  end

  tap_decode_t         dec;
  logic [IR_WIDTH-1:0] ir_sr;
  logic [IR_WIDTH-1:0] ir_out;
  logic [IR_WIDTH-1:0] ir_cap;
  logic                bypass_reg;
  logic                bypass_sel;
  logic                idcode_sel;
  logic                idcode_tdo;
  logic                user_sel;
  logic                tdo;

  jtag_tap_fsm u_fsm (
    .TCK (TCK),
    .RST (RST),
    .TMS (bus.TMS),
    .dec (dec)
  );

  always_comb begin
    ir_cap      = '1;
    ir_cap[1:0] = IR_CAPTURE;
  end

  always_ff @(posedge TCK) begin
    if (RST) begin
      ir_sr  <= '0;
      ir_out <= RESET_OP;
    end else begin
      if (dec.cap_ir)     ir_sr <= ir_cap;
      else if (dec.sh_ir) ir_sr <= {bus.TDI, ir_sr[IR_WIDTH-1:1]};
      if (dec.tlr)         ir_out <= RESET_OP;
      else if (dec.upd_ir) ir_out <= ir_sr;
    end
  end

  assign bypass_sel = is_bypass_op(32'(ir_out), IR_WIDTH);

  always_ff @(posedge TCK) begin
    if (RST)                            bypass_reg <= 1'b0;
    else if (dec.cap_dr && bypass_sel)  bypass_reg <= 1'b0;
    else if (dec.sh_dr && bypass_sel)   bypass_reg <= bus.TDI;
  end

`ifdef JTAG_IDCODE_EN
  logic [31:0] idcode_sr;

  assign idcode_sel = !bypass_sel && (ir_out == IDCODE_OP);
  assign idcode_tdo = idcode_sr[0];

  always_ff @(posedge TCK) begin
    if (RST)                           idcode_sr <= IDCODE_VALUE;
    else if (dec.cap_dr && idcode_sel) idcode_sr <= IDCODE_VALUE;
    else if (dec.sh_dr && idcode_sel)  idcode_sr <= {bus.TDI, idcode_sr[31:1]};
  end
`else
  assign idcode_sel = 1'b0;
  assign idcode_tdo = 1'b0;
`endif

  assign user_sel = !bypass_sel && !idcode_sel;

  // Shift stages present their LSB; every non-shift state drives 0.
  always_comb begin
    tdo = 1'b0;
    if (dec.sh_ir) begin
      tdo = ir_sr[0];
    end else if (dec.sh_dr) begin
      if (bypass_sel)      tdo = bypass_reg;
      else if (idcode_sel) tdo = idcode_tdo;
      else                 tdo = bus.user_tdo;
    end
  end

  assign bus.TDO        = tdo;
  assign bus.TDO_EN     = dec.sh_ir | dec.sh_dr;
  assign bus.ir_out     = ir_out;
  assign bus.user_sel   = user_sel;
  assign bus.user_tdi   = bus.TDI;
  assign bus.capture_dr = dec.cap_dr & user_sel;
  assign bus.shift_dr   = dec.sh_dr & user_sel;
  assign bus.update_dr  = dec.upd_dr & user_sel;
  assign bus.tlr        = dec.tlr;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Scoreboard bench for jtag_tap_ctrl: a table-driven TAP model predicts every cycle's
// outputs from directed scans and a random TMS/TDI walk; follows the JTAG_IDCODE_EN build.
module tb_jtag_tap_ctrl;

  localparam int          IRW          = 4;
  localparam logic [3:0]  IDCODE_OP    = 4'b0001;
  localparam logic [31:0] IDCODE_VALUE = 32'h1000_0001;
`ifdef JTAG_IDCODE_EN
  localparam bit          IDCODE_PRESENT = 1'b1;
  localparam logic [3:0]  RESET_OP       = 4'b0001;
`else
  localparam bit          IDCODE_PRESENT = 1'b0;
  localparam logic [3:0]  RESET_OP       = 4'b1111;
`endif

  typedef struct {
    bit       tlr;
    bit       tdo_en;
    bit       tdo;
    bit       user_sel;
    bit       cap;
    bit       sh;
    bit       upd;
    bit [3:0] ir_out;
    int       cyc;
  } exp_t;

  logic TCK = 1'b0;
  logic RST = 1'b1;

  jtag_tap_ctrl_if #(.IR_WIDTH(IRW)) bus ();

  jtag_tap_ctrl #(
    .IR_WIDTH     (IRW),
    .IDCODE_OP    (IDCODE_OP),
    .IDCODE_VALUE (IDCODE_VALUE)
  ) dut (
    .TCK (TCK),
    .RST (RST),
    .bus (bus)
  );

  always #5 TCK = ~TCK;

  exp_t     exp_q[$];
  string    nxt0[string];
  string    nxt1[string];
  string    m_state  = "TLR";
  bit [3:0] m_ir     = RESET_OP;
  bit       m_irq[$];
  bit       m_drq[$];
  bit       cur_utdo = 1'b0;
  int       checks   = 0;
  int       errors   = 0;
  int       cycle    = 0;

  function automatic void add_edge(string s, string n0, string n1);
    nxt0[s] = n0;
    nxt1[s] = n1;
  endfunction

  function automatic void init_table();
    add_edge("TLR",   "RTI",   "TLR");
    add_edge("RTI",   "RTI",   "SelDR");
    add_edge("SelDR", "CapDR", "SelIR");
    add_edge("CapDR", "ShDR",  "Ex1DR");
    add_edge("ShDR",  "ShDR",  "Ex1DR");
    add_edge("Ex1DR", "PauDR", "UpdDR");
    add_edge("PauDR", "PauDR", "Ex2DR");
    add_edge("Ex2DR", "ShDR",  "UpdDR");
    add_edge("UpdDR", "RTI",   "SelDR");
    add_edge("SelIR", "CapIR", "TLR");
    add_edge("CapIR", "ShIR",  "Ex1IR");
    add_edge("ShIR",  "ShIR",  "Ex1IR");
    add_edge("Ex1IR", "PauIR", "UpdIR");
    add_edge("PauIR", "PauIR", "Ex2IR");
    add_edge("Ex2IR", "ShIR",  "UpdIR");
    add_edge("UpdIR", "RTI",   "SelDR");
  endfunction

  // 0 = BYPASS, 1 = IDCODE, 2 = user register
  function automatic int dr_kind(bit [3:0] op);
    if (op == 4'b1111) return 0;
    if (IDCODE_PRESENT && op == IDCODE_OP) return 1;
    return 2;
  endfunction

  // Advance the model across one rising edge and queue the outputs expected after it.
  function automatic void model_step(bit rst, bit tms, bit tdi, bit utdo);
    exp_t      e;
    bit [31:0] idv;
    int        kind;
    idv = IDCODE_VALUE;
    if (rst) begin
      m_state = "TLR";
      m_ir    = RESET_OP;
    end else begin
      if (m_state == "CapIR") begin
        m_irq.delete();
        for (int i = 0; i < IRW; i++) m_irq.push_back(i != 1);
      end else if (m_state == "ShIR") begin
        void'(m_irq.pop_front());
        m_irq.push_back(tdi);
      end else if (m_state == "UpdIR") begin
        for (int i = 0; i < IRW; i++) m_ir[i] = m_irq[i];
      end else if (m_state == "TLR") begin
        m_ir = RESET_OP;
      end else if (m_state == "CapDR") begin
        m_drq.delete();
        if (dr_kind(m_ir) == 0) m_drq.push_back(1'b0);
        else if (dr_kind(m_ir) == 1)
          for (int i = 0; i < 32; i++) m_drq.push_back(idv[i]);
        else m_drq.push_back(1'b0);
      end else if (m_state == "ShDR") begin
        void'(m_drq.pop_front());
        m_drq.push_back(tdi);
      end
      m_state = tms ? nxt1[m_state] : nxt0[m_state];
    end
    kind       = dr_kind(m_ir);
    e.tlr      = (m_state == "TLR");
    e.tdo_en   = (m_state == "ShIR") || (m_state == "ShDR");
    e.tdo      = 1'b0;
    if (m_state == "ShIR")      e.tdo = m_irq[0];
    else if (m_state == "ShDR") e.tdo = (kind == 2) ? utdo : m_drq[0];
    e.user_sel = (kind == 2);
    e.cap      = e.user_sel && (m_state == "CapDR");
    e.sh       = e.user_sel && (m_state == "ShDR");
    e.upd      = e.user_sel && (m_state == "UpdDR");
    e.ir_out   = m_ir;
    e.cyc      = cycle;
    exp_q.push_back(e);
  endfunction

  function automatic void check_output(string name, logic [31:0] act, logic [31:0] expv, int cyc);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d actual=%0h expected=%0h", name, cyc, act, expv);
    end
  endfunction

  task automatic apply_stimulus(input bit rst, input bit tms, input bit tdi, input bit utdo);
    @(negedge TCK);
    #1;
    RST          = rst;
    bus.TMS      = tms;
    bus.TDI      = tdi;
    bus.user_tdo = utdo;
    cycle++;
    model_step(rst, tms, tdi, utdo);
  endtask

  task automatic step(input bit tms, input bit tdi);
    apply_stimulus(1'b0, tms, tdi, cur_utdo);
  endtask

  // From RTI: shift v into the IR LSB-first, update, return to RTI.
  task automatic load_ir(input bit [3:0] v);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < IRW; i++) step(i == IRW - 1, v[i]);
    step(1, 0); step(0, 0);
  endtask

  // From RTI: n-bit DR scan, optionally pausing after bit pause_at, then update to RTI.
  task automatic scan_dr(input int n, input bit [31:0] pat, input int pause_at);
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) begin
        step(1, pat[i]);
      end else if (i == pause_at) begin
        step(1, pat[i]); step(0, 0); step(0, 0); step(1, 0); step(0, 0);
      end else begin
        step(0, pat[i]);
      end
    end
    step(1, 0); step(0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge TCK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("tlr",        32'(bus.tlr),        32'(e.tlr),      e.cyc);
        check_output("tdo_en",     32'(bus.TDO_EN),     32'(e.tdo_en),   e.cyc);
        check_output("tdo",        32'(bus.TDO),        32'(e.tdo),      e.cyc);
        check_output("ir_out",     32'(bus.ir_out),     32'(e.ir_out),   e.cyc);
        check_output("user_sel",   32'(bus.user_sel),   32'(e.user_sel), e.cyc);
        check_output("capture_dr", 32'(bus.capture_dr), 32'(e.cap),      e.cyc);
        check_output("shift_dr",   32'(bus.shift_dr),   32'(e.sh),       e.cyc);
        check_output("update_dr",  32'(bus.update_dr),  32'(e.upd),      e.cyc);
        check_output("user_tdi",   32'(bus.user_tdi),   32'(bus.TDI),    e.cyc);
      end
    end
  end

  initial begin : driver
    bus.TMS      = 1'b1;
    bus.TDI      = 1'b0;
    bus.user_tdo = 1'b0;
    init_table();
    for (int i = 0; i < IRW; i++) m_irq.push_back(1'b0);
    m_drq.push_back(1'b0);
    $display("[TB] start, IDCODE register present = %0d", IDCODE_PRESENT);

    apply_stimulus(1, 1, 0, 0);
    apply_stimulus(1, 0, 1, 0);

    // Enter ShDR, shift a little, then five TMS=1 edges back to TLR.
    step(0, 0); step(1, 0); step(0, 0); step(0, 0); step(0, 1); step(0, 0);
    repeat (5) step(1, 0);

    step(0, 0);
    scan_dr(32, $urandom, -1);

    load_ir(4'b1111);
    scan_dr(4, 32'b1101, -1);

    cur_utdo = 1'b1;
    load_ir(4'b0101);
    scan_dr(6, $urandom, 2);
    cur_utdo = 1'b0;

    // RST in the middle of an IR shift: no update may happen.
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    step(0, 0); step(0, 1);
    apply_stimulus(1, 0, 1, 0);
    step(0, 0);

    load_ir(4'b0001);
    scan_dr(8, $urandom, 3);
    step(1, 1); step(1, 1); step(1, 1); step(1, 1); step(1, 1);
    step(0, 0);
    scan_dr(33, $urandom, 20);

    repeat (3000) begin
      apply_stimulus($urandom_range(0, 99) == 0,
                     $urandom_range(0, 99) < 35,
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
    end

    @(negedge TCK);
    #2;
    check_output("queue_drained", 32'(exp_q.size()), 32'd0, cycle);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
